// File: rtl/stream_demux1to2_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: channel ids,
// default widths and the per-slot state encoding.
package stream_demux1to2_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  localparam logic STREAM_CH0 = 1'b0;
  localparam logic STREAM_CH1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/stream_reg_slot.sv
// One-entry valid/ready register slice. A load and a drain in the same cycle
// replace the held beat, giving one beat per cycle of throughput.
module stream_reg_slot
  import stream_demux1to2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_free
);

  slot_state_t       r_state;
  logic [DATA_W-1:0] r_data;

  // The producer only loads when o_free is high, so a load in FULL implies a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (i_load) begin
            r_state <= SLOT_FULL;
            r_data  <= i_data;
          end
        end
        SLOT_FULL: begin
          if (i_load) begin
            r_data <= i_data;
          end else if (i_ready) begin
            r_state <= SLOT_EMPTY;
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_data  = r_data;
  assign o_free  = (r_state == SLOT_EMPTY) | i_ready;

endmodule

// File: rtl/stream_demux1to2.sv
// 1-to-2 stream demultiplexer with a registered slot per output channel.
// Optional per-channel delivered-beat counters: define STREAM_DEMUX_COUNT_EN.
module stream_demux1to2
  import stream_demux1to2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  out0_cnt,
  output logic [CNT_W-1:0]  out1_cnt
);

  logic w_free0;
  logic w_free1;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // Only the selected channel's slot can stall the input.
  assign in_ready = (in_sel == STREAM_CH1) ? w_free1 : w_free0;
  assign w_accept = in_valid & in_ready;
  assign w_load0  = w_accept & (in_sel == STREAM_CH0);
  assign w_load1  = w_accept & (in_sel == STREAM_CH1);

  stream_reg_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load0),
    .i_data  (in_data),
    .i_ready (out0_ready),
    .o_valid (out0_valid),
    .o_data  (out0_data),
    .o_free  (w_free0)
  );

  stream_reg_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load1),
    .i_data  (in_data),
    .i_ready (out1_ready),
    .o_valid (out1_valid),
    .o_data  (out1_data),
    .o_free  (w_free1)
  );

`ifdef STREAM_DEMUX_COUNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Counters wrap naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (out1_valid && out1_ready) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign out0_cnt = r_cnt0;
  assign out1_cnt = r_cnt1;
`else
  assign out0_cnt = '0;
  assign out1_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux1to2.sv
// Self-checking bench for stream_demux1to2: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the two channels.
module tb_stream_demux1to2;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out0_data;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic [CNT_W-1:0]  out0_cnt;
  logic [CNT_W-1:0]  out1_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  stream_demux1to2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out0_cnt   (out0_cnt),
    .out1_cnt   (out1_cnt)
  );

  // Reference model: each channel is a capacity-1 queue plus its last payload.
  logic [DATA_W-1:0] mq0[$];
  logic [DATA_W-1:0] mq1[$];
  logic [DATA_W-1:0] mdata0 = '0;
  logic [DATA_W-1:0] mdata1 = '0;
  int mcnt0 = 0;
  int mcnt1 = 0;

  function automatic logic m_ready();
    if (in_sel) return (mq1.size() == 0) || out1_ready;
    return (mq0.size() == 0) || out0_ready;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int c);
`ifdef STREAM_DEMUX_COUNT_EN
    return CNT_W'(c % (1 << CNT_W));
`else
    return '0;
`endif
  endfunction

  task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic tick();
    logic acc, d0, d1;
    acc = in_valid && m_ready();
    d0  = (mq0.size() != 0) && out0_ready;
    d1  = (mq1.size() != 0) && out1_ready;
    @(posedge clk);
    if (rst) begin
      mq0.delete(); mq1.delete();
      mdata0 = '0; mdata1 = '0;
      mcnt0 = 0; mcnt1 = 0;
    end else begin
      if (d0) begin void'(mq0.pop_front()); mcnt0++; end
      if (d1) begin void'(mq1.pop_front()); mcnt1++; end
      if (acc && !in_sel) begin mq0.push_back(in_data); mdata0 = in_data; end
      if (acc &&  in_sel) begin mq1.push_back(in_data); mdata1 = in_data; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (out0_valid !== 1'b0) $display("[TB] FAIL reset_v0 got %b want 0", out0_valid); else passed++;
    checks++; if (out1_valid !== 1'b0) $display("[TB] FAIL reset_v1 got %b want 0", out1_valid); else passed++;
    checks++; if (out0_data !== 8'h00) $display("[TB] FAIL reset_d0 got %h want 00", out0_data); else passed++;
    checks++; if (out1_data !== 8'h00) $display("[TB] FAIL reset_d1 got %h want 00", out1_data); else passed++;
    checks++; if (out0_cnt !== 4'd0 || out1_cnt !== 4'd0)
      $display("[TB] FAIL reset_cnt got %0d/%0d want 0/0", out0_cnt, out1_cnt); else passed++;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    in_sel = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready_sel1 got %b want 1", in_ready); else passed++;
    tick();
  endtask

  task automatic test_steering();
    int c0, c1;
    c0 = mcnt0; c1 = mcnt1;
    drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    tick();
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hA5)
      $display("[TB] FAIL steer_ch0 got v=%b d=%h want v=1 d=a5", out0_valid, out0_data); else passed++;
    drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    tick();
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h3C || out0_valid !== 1'b0)
      $display("[TB] FAIL steer_ch1 got v1=%b d1=%h v0=%b want 1/3c/0", out1_valid, out1_data, out0_valid); else passed++;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checks++; if (out0_cnt !== exp_cnt(c0 + 1) || out1_cnt !== exp_cnt(c1 + 1))
      $display("[TB] FAIL steer_cnt got %0d/%0d want %0d/%0d", out0_cnt, out1_cnt, exp_cnt(c0 + 1), exp_cnt(c1 + 1)); else passed++;
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready got %b want 0", in_ready); else passed++;
    tick();
    tick();
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h11)
      $display("[TB] FAIL bp_hold got v=%b d=%h want v=1 d=11", out0_valid, out0_data); else passed++;
    out0_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready got %b want 1", in_ready); else passed++;
    tick();
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h22)
      $display("[TB] FAIL bp_reload got v=%b d=%h want v=1 d=22", out0_valid, out0_data); else passed++;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_isolation();
    drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL iso_in_ready got %b want 1", in_ready); else passed++;
    tick();
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h77)
      $display("[TB] FAIL iso_ch1 got v=%b d=%h want v=1 d=77", out1_valid, out1_data); else passed++;
    checks++; if (out0_valid !== 1'b1 || out0_data !== 8'h55)
      $display("[TB] FAIL iso_ch0 got v=%b d=%h want v=1 d=55", out0_valid, out0_data); else passed++;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_streaming();
    int c0, c1, stalls, errs;
    c0 = mcnt0; c1 = mcnt1; stalls = 0; errs = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'(i % 2), 8'($urandom), 1'b1, 1'b1);
      @(negedge clk);
      if (in_ready !== 1'b1) stalls++;
      tick();
      if (i % 2 == 0 && (out0_valid !== 1'b1 || out0_data !== in_data)) errs++;
      if (i % 2 == 1 && (out1_valid !== 1'b1 || out1_data !== in_data)) errs++;
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checks++; if (stalls !== 0) $display("[TB] FAIL stream_stalls got %0d want 0", stalls); else passed++;
    checks++; if (errs !== 0) $display("[TB] FAIL stream_order got %0d bad beats want 0", errs); else passed++;
    checks++; if (out0_cnt !== exp_cnt(c0 + 8) || out1_cnt !== exp_cnt(c1 + 8))
      $display("[TB] FAIL stream_cnt got %0d/%0d want %0d/%0d", out0_cnt, out1_cnt, exp_cnt(c0 + 8), exp_cnt(c1 + 8)); else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      @(negedge clk);
      if (in_ready !== m_ready()) begin
        errs++;
        if (errs < 5) $display("[TB] FAIL rand_in_ready cycle %0d got %b want %b", i, in_ready, m_ready());
      end
      tick();
      if (out0_valid !== (mq0.size() != 0) || out1_valid !== (mq1.size() != 0) ||
          out0_data !== mdata0 || out1_data !== mdata1 ||
          out0_cnt !== exp_cnt(mcnt0) || out1_cnt !== exp_cnt(mcnt1)) begin
        errs++;
        if (errs < 5) $display("[TB] FAIL rand_out cycle %0d got v=%b%b d=%h/%h c=%0d/%0d want v=%b%b d=%h/%h c=%0d/%0d",
          i, out0_valid, out1_valid, out0_data, out1_data, out0_cnt, out1_cnt,
          mq0.size() != 0, mq1.size() != 0, mdata0, mdata1, exp_cnt(mcnt0), exp_cnt(mcnt1));
      end
    end
    checks++; if (errs !== 0) $display("[TB] FAIL rand_total got %0d errors want 0", errs); else passed++;
  endtask

  task automatic test_midop_reset();
    drive(1'b1, 1'b0, 8'h9A, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'hB7, 1'b0, 1'b0);
    tick();
    checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1)
      $display("[TB] FAIL midrst_fill got %b%b want 11", out0_valid, out1_valid); else passed++;
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== 8'h00 || out1_data !== 8'h00)
      $display("[TB] FAIL midrst_clear got v=%b%b d=%h/%h want 00 00/00", out0_valid, out1_valid, out0_data, out1_data); else passed++;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] want;
`ifdef STREAM_DEMUX_COUNT_EN
    want = 4'd1;
`else
    want = 4'd0;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    checks++; if (out0_cnt !== want) $display("[TB] FAIL wrap_cnt0 got %0d want %0d", out0_cnt, want); else passed++;
    checks++; if (out1_cnt !== 4'd0) $display("[TB] FAIL wrap_cnt1 got %0d want 0", out1_cnt); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    test_reset();
    test_steering();
    test_backpressure();
    test_isolation();
    test_streaming();
    test_random();
    test_midop_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
